// File: rtl/result_collector.sv
// ============================================================================
// Module   : result_collector
// Purpose  : Snapshots a systolic-array result grid and drains it row-major over
//            a valid/ready stream. Optional: RESULT_COLLECTOR_AUTO_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_collector #(
    parameter int ARRAY_WIDTH  = 2,
    parameter int ARRAY_HEIGHT = 2,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic [2*DATA_WIDTH-1:0]               c_array_input [ARRAY_HEIGHT-1:0][ARRAY_WIDTH-1:0],
    output logic                                  array_reset_n [ARRAY_HEIGHT-1:0][ARRAY_WIDTH-1:0],
    output logic                                  busy,
    output logic [2*DATA_WIDTH-1:0]               out_data,
    output logic [((ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1)-1:0] out_row,
    output logic [((ARRAY_WIDTH  > 1) ? $clog2(ARRAY_WIDTH)  : 1)-1:0] out_col,
    output logic                                  out_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  done
);

    localparam int c_ROW_W = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam int c_COL_W = (ARRAY_WIDTH  > 1) ? $clog2(ARRAY_WIDTH)  : 1;
    localparam logic [c_ROW_W-1:0] c_ROW_MAX = c_ROW_W'(ARRAY_HEIGHT - 1);
    localparam logic [c_COL_W-1:0] c_COL_MAX = c_COL_W'(ARRAY_WIDTH - 1);
`ifdef RESULT_COLLECTOR_AUTO_CLEAR_EN
    localparam logic c_AUTO_CLEAR = 1'b1;
`else
    localparam logic c_AUTO_CLEAR = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_CLEAR  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [2*DATA_WIDTH-1:0] r_shadow [ARRAY_HEIGHT-1:0][ARRAY_WIDTH-1:0];
    logic [c_ROW_W-1:0]      r_row;
    logic [c_COL_W-1:0]      r_col;
    logic                    r_done;
    logic                    w_last;
    logic                    w_xfer;
    logic                    w_drain_end;

    assign w_last      = (r_row == c_ROW_MAX) && (r_col == c_COL_MAX);
    assign w_xfer      = (r_state == S_STREAM) && out_ready;
    // Any return to IDLE from a non-IDLE state is the end of a completed drain.
    assign w_drain_end = (r_state != S_IDLE) && (w_state_next == S_IDLE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_xfer && w_last) begin
                    w_state_next = c_AUTO_CLEAR ? S_CLEAR : S_IDLE;
                end
            end
            S_CLEAR: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_done  <= 1'b0;
            for (int r = 0; r < ARRAY_HEIGHT; r++) begin
                for (int c = 0; c < ARRAY_WIDTH; c++) begin
                    r_shadow[r][c] <= '0;
                end
            end
        end else begin
            r_state <= w_state_next;
            r_done  <= w_drain_end;
            if ((r_state == S_IDLE) && start) begin
                r_shadow <= c_array_input;
                r_row    <= '0;
                r_col    <= '0;
            end else if (w_xfer && !w_last) begin
                if (r_col == c_COL_MAX) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < ARRAY_HEIGHT; r++) begin
            for (int c = 0; c < ARRAY_WIDTH; c++) begin
`ifdef RESULT_COLLECTOR_AUTO_CLEAR_EN
                array_reset_n[r][c] = (r_state != S_CLEAR);
`else
                array_reset_n[r][c] = 1'b1;
`endif
            end
        end
    end

    assign out_valid = (r_state == S_STREAM);
    assign busy      = (r_state != S_IDLE);
    assign out_last  = out_valid && w_last;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_data  = r_shadow[r_row][r_col];
    assign done      = r_done;

endmodule

`default_nettype wire

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter ARRAY_WIDTH, default 2, number of array columns.
REQ-002 SHALL have parameter ARRAY_HEIGHT, default 2, number of array rows.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, operand width; result width is 2*DATA_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to capture and drain the array results.
REQ-007 SHALL have port c_array_input  input  2*DATA_WIDTH per element, unpacked [ARRAY_HEIGHT-1:0][ARRAY_WIDTH-1:0]  per-cell accumulator values from the array.
REQ-008 SHALL have port array_reset_n  output  1 per element, unpacked [ARRAY_HEIGHT-1:0][ARRAY_WIDTH-1:0]  per-cell soft clear, active-low.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port out_data  output  2*DATA_WIDTH  current result element.
REQ-011 SHALL have port out_row  output  clog2(ARRAY_HEIGHT), minimum 1  row index of out_data.
REQ-012 SHALL have port out_col  output  clog2(ARRAY_WIDTH), minimum 1  column index of out_data.
REQ-013 SHALL have port out_last  output  1  high with the final element (row H-1, col W-1).
REQ-014 SHALL have port out_valid  output  1  out_data/out_row/out_col/out_last valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts; transfer occurs when out_valid and out_ready are both high at a rising edge.
REQ-016 SHALL have port done  output  1  one-cycle pulse when a drain completes.

Function
REQ-017 SHALL implement states IDLE, STREAM, CLEAR.
REQ-018 In IDLE with start high at a rising edge, SHALL load every c_array_input element into an internal shadow buffer, set row and col indices to 0, and enter STREAM.
REQ-019 out_valid SHALL be high exactly while in STREAM, first asserting the cycle after start is sampled.
REQ-020 out_data SHALL equal shadow[out_row][out_col]; elements SHALL be emitted row-major: col increments first and wraps to 0 at ARRAY_WIDTH-1, incrementing row.
REQ-021 While out_valid is high and out_ready is low, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-022 c_array_input changes after capture SHALL NOT affect emitted data.
REQ-023 On the transfer with out_last high, SHALL leave STREAM: go to CLEAR if auto-clear is compiled in, else to IDLE.
REQ-024 CLEAR SHALL last exactly one cycle, drive all array_reset_n elements low during it, and then go to IDLE.
REQ-025 array_reset_n SHALL be high in all states other than CLEAR.
REQ-026 done SHALL pulse high for one cycle in the first IDLE cycle following a completed drain.
REQ-027 start SHALL be ignored when not in IDLE.
REQ-028 out_ready while not in STREAM SHALL have no effect.
REQ-029 For a 1x1 array, out_last SHALL be high on the first element, and one transfer completes the drain.

Reset
REQ-030 On reset_n low, SHALL immediately, independent of clk, force: state IDLE, out_valid 0, busy 0, done 0, out_last 0, out_row 0, out_col 0, out_data 0, shadow buffer 0, all array_reset_n 1.
REQ-031 Reset asserted mid-drain SHALL abandon the drain with no done pulse and no CLEAR cycle.

Configuration
REQ-032 SHALL use macro RESULT_COLLECTOR_AUTO_CLEAR_EN: when defined, CLEAR state follows the last transfer per REQ-024; when undefined, CLEAR is unreachable, array_reset_n is tied high, and the last transfer returns directly to IDLE.

Verification
REQ-033 2x2, c = {[0][0]=0x0011,[0][1]=0x0022,[1][0]=0x0033,[1][1]=0x0044}, out_ready held 1, start pulse -> 0x0011,0x0022,0x0033,0x0044 on 4 consecutive cycles, out_last only on 0x0044, done 1 cycle later (2 later with auto-clear).
REQ-034 Same data, out_ready low for 3 cycles on the second element -> 0x0022 with row 0, col 1 held stable for 3 cycles; no element skipped or duplicated.
REQ-035 After start, change all c inputs to 0xFFFF -> emitted data remains 0x0011..0x0044.
REQ-036 With RESULT_COLLECTOR_AUTO_CLEAR_EN defined -> all array_reset_n low for exactly 1 cycle after the last transfer; undefined -> array_reset_n never low.
REQ-037 reset_n low after the 2nd transfer -> out_valid 0 immediately, IDLE, no done pulse; a new start then drains from element [0][0].
REQ-038 start pulsed during STREAM -> ignored; drain order and count unchanged.
